// File: rtl/mac_pkg.sv
// Shared constants, types and the output quantiser for the MAC bank back-end stages.
package mac_pkg;

  localparam int NUM_MAC       = 12;
  localparam int PSUM_W        = 20;
  localparam int BIAS_W        = 16;
  localparam int ACC_W         = 32;
  localparam int OUT_W         = 8;
  localparam int GRP_W         = 8;
  localparam int SHIFT_W       = 5;
  localparam int LANES_PER_ADD = 4;
  localparam int NUM_ADD       = NUM_MAC / LANES_PER_ADD;
  localparam int GSUM_W        = PSUM_W + 2;

  typedef logic signed [PSUM_W-1:0] psum_t;
  typedef logic signed [GSUM_W-1:0] gsum_t;
  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic signed [OUT_W-1:0]  out_t;

  typedef struct packed {
    logic signed [BIAS_W-1:0] bias;
    logic [GRP_W-1:0]         num_grp;
    logic [SHIFT_W-1:0]       shift;
    logic                     relu;
  } cfg_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_e;

  localparam logic signed [ACC_W:0] Q_MAX = (ACC_W+1)'(2**(OUT_W-1) - 1);
  localparam logic signed [ACC_W:0] Q_MIN = -(ACC_W+1)'(2**(OUT_W-1));

  // One guard bit above ACC_W keeps the rounding add from wrapping near full scale.
  function automatic out_t quant_sat(input acc_t acc, input logic [SHIFT_W-1:0] shift,
                                     input logic relu);
    logic signed [ACC_W:0] r;
    logic signed [ACC_W:0] rnd;
    r   = {acc[ACC_W-1], acc};
    rnd = '0;
    if (shift != '0) begin
      rnd = (ACC_W+1)'(1) <<< (shift - SHIFT_W'(1));
      r   = (r + rnd) >>> shift;
    end
    if (r > Q_MAX) r = Q_MAX;
    else if (r < Q_MIN) r = Q_MIN;
    if (relu && (r < 0)) r = '0;
    return out_t'(r);
  endfunction

endpackage

// File: rtl/psum_adder_tree.sv
// Reduces NUM_MAC signed lanes: registered groups of four, then a combinational final sum.
module psum_adder_tree
  import mac_pkg::*;
(
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      vld_i,
  input  logic                      clr_i,
  input  logic [NUM_MAC*PSUM_W-1:0] psum_i,
  output logic                      vld_o,
  output acc_t                      total_o
);

  gsum_t gsum_d  [NUM_ADD];
  gsum_t gsum_p1 [NUM_ADD];
  logic  vld_p1;
  psum_t lane;

  always_comb begin
    lane = '0;
    for (int g = 0; g < NUM_ADD; g++) begin
      gsum_d[g] = '0;
      for (int l = 0; l < LANES_PER_ADD; l++) begin
        lane      = psum_i[(g*LANES_PER_ADD + l)*PSUM_W +: PSUM_W];
        gsum_d[g] = gsum_d[g] + gsum_t'(lane);
      end
    end
  end

  // S1 boundary: group sums registered with their valid
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p1 <= 1'b0;
      for (int g = 0; g < NUM_ADD; g++) gsum_p1[g] <= '0;
    end else begin
      vld_p1 <= vld_i & ~clr_i;
      if (vld_i) begin
        for (int g = 0; g < NUM_ADD; g++) gsum_p1[g] <= gsum_d[g];
      end
    end
  end

  always_comb begin
    total_o = '0;
    for (int g = 0; g < NUM_ADD; g++) total_o = total_o + acc_t'(gsum_p1[g]);
  end

  assign vld_o = vld_p1;

endmodule

// File: rtl/mac_psum_accum_quant.sv
// Partial-sum reduction, bias add, multi-group accumulation and 8-bit quantisation.
module mac_psum_accum_quant
  import mac_pkg::*;
(
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      vld_i,
  input  logic [NUM_MAC*PSUM_W-1:0] iPsum,
  input  logic signed [BIAS_W-1:0]  iBias,
  input  logic [GRP_W-1:0]          iNumGrp,
  input  logic [SHIFT_W-1:0]        iShift,
  input  logic                      iRelu,
  input  logic                      iClear,
  output logic signed [OUT_W-1:0]   oOut,
  output logic                      oVld,
  output logic                      oBusy
);

  logic   tree_vld;
  acc_t   total;
  cfg_t   cfg_p1;

  state_e             state_q, state_d;
  logic [GRP_W-1:0]   cnt_q, cnt_d;
  acc_t               acc_q, acc_d;
  logic [GRP_W-1:0]   numgrp_q, numgrp_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic               relu_q, relu_d;
  logic               done_q, done_d;
  out_t               out_q;
  logic               vld_p3;

  psum_adder_tree u_tree (
    .clk     (clk),
    .rstn    (rstn),
    .vld_i   (vld_i),
    .clr_i   (iClear),
    .psum_i  (iPsum),
    .vld_o   (tree_vld),
    .total_o (total)
  );

  // S1 boundary: config rides alongside each beat so the first beat's copy reaches the FSM
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cfg_p1 <= '0;
    end else if (vld_i) begin
      cfg_p1 <= '{bias: iBias, num_grp: iNumGrp, shift: iShift, relu: iRelu};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    numgrp_d = numgrp_q;
    shift_d  = shift_q;
    relu_d   = relu_q;
    done_d   = 1'b0;
    if (iClear) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (tree_vld) begin
      case (state_q)
        ST_IDLE: begin
          acc_d    = acc_t'(cfg_p1.bias) + total;
          cnt_d    = GRP_W'(1);
          numgrp_d = cfg_p1.num_grp;
          shift_d  = cfg_p1.shift;
          relu_d   = cfg_p1.relu;
          if (cfg_p1.num_grp <= GRP_W'(1)) done_d  = 1'b1;
          else                             state_d = ST_ACC;
        end
        ST_ACC: begin
          acc_d = acc_q + total;
          cnt_d = cnt_q + GRP_W'(1);
          if (cnt_d >= numgrp_q) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // S2 boundary: accumulator, beat count and the pixel's latched config
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      numgrp_q <= '0;
      shift_q  <= '0;
      relu_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      numgrp_q <= numgrp_d;
      shift_q  <= shift_d;
      relu_q   <= relu_d;
      done_q   <= done_d;
    end
  end

  // S3 boundary: quantised pixel
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_q  <= '0;
      vld_p3 <= 1'b0;
    end else begin
      vld_p3 <= done_q & ~iClear;
      if (done_q && !iClear) out_q <= quant_sat(acc_q, shift_q, relu_q);
    end
  end

  assign oOut  = out_q;
  assign oVld  = vld_p3;
  assign oBusy = (state_q == ST_ACC) | tree_vld | done_q;

endmodule
